// File: rtl/branch_pkg.sv
// Shared branch encodings, sequencer state enumeration and default widths.
// Used by branch_sequencer, its interface and the external comparator.
package branch_pkg;
    localparam int ADDR_WIDTH_DEF   = 16;
    localparam int BR_CTRL_W_DEF    = 2;
    localparam int FLUSH_CYCLES_DEF = 2;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_GT   = 2'b10;
    localparam logic [1:0] BR_LT   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_OPND,
        ST_EVAL,
        ST_FLUSH
    } state_e;
endpackage

// File: rtl/branch_sequencer_if.sv
// Decode / comparator / PC-redirect signal bundle around branch_sequencer.
// slave = the sequencer, master = the surrounding pipeline.
interface branch_sequencer_if #(
    parameter int ADDR_WIDTH           = 16,
    parameter int BRANCH_CONTROL_WIDTH = 2
);
    logic                            br_valid;
    logic [BRANCH_CONTROL_WIDTH-1:0] br_control;
    logic [ADDR_WIDTH-1:0]           br_pc;
    logic [ADDR_WIDTH-1:0]           br_offset;
    logic                            br_ready;
    logic                            opnd_ready;
    logic [BRANCH_CONTROL_WIDTH-1:0] cmp_control;
    logic                            cmp_branch;
    logic                            pc_load;
    logic [ADDR_WIDTH-1:0]           pc_target;
    logic                            flush;
    logic                            stall;

    modport slave (
        input  br_valid, br_control, br_pc, br_offset, opnd_ready, cmp_branch,
        output br_ready, cmp_control, pc_load, pc_target, flush, stall
    );

    modport master (
        output br_valid, br_control, br_pc, br_offset, opnd_ready, cmp_branch,
        input  br_ready, cmp_control, pc_load, pc_target, flush, stall
    );
endinterface

// File: rtl/branch_stats.sv
// Saturating taken / not-taken counters, bumped on each EVAL exit.
// Only instantiated when BRANCH_STATS_EN is defined.
module branch_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        eval_done_i,
    input  logic        taken_i,
    output logic [15:0] taken_count_o,
    output logic [15:0] not_taken_count_o
);
    logic [15:0] taken_q, taken_d;
    logic [15:0] ntaken_q, ntaken_d;

    always_comb begin
        taken_d  = taken_q;
        ntaken_d = ntaken_q;
        if (eval_done_i) begin
            if (taken_i && taken_q != 16'hFFFF)
                taken_d = taken_q + 16'd1;
            if (!taken_i && ntaken_q != 16'hFFFF)
                ntaken_d = ntaken_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            taken_q  <= '0;
            ntaken_q <= '0;
        end else begin
            taken_q  <= taken_d;
            ntaken_q <= ntaken_d;
        end
    end

    assign taken_count_o     = taken_q;
    assign not_taken_count_o = ntaken_q;
endmodule

// File: rtl/branch_sequencer.sv
// Conditional branch sequencer: waits for hazard-free operands, evaluates via the
// external comparator, redirects PC and flushes on taken. Optional stats: BRANCH_STATS_EN.
module branch_sequencer
    import branch_pkg::*;
#(
    parameter int ADDR_WIDTH           = ADDR_WIDTH_DEF,
    parameter int BRANCH_CONTROL_WIDTH = BR_CTRL_W_DEF,
    parameter int FLUSH_CYCLES         = FLUSH_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    branch_sequencer_if.slave bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]       taken_count,
    output logic [15:0]       not_taken_count
`endif
);
    localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYCLES);

    state_e                          state_q, state_d;
    logic [BRANCH_CONTROL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [ADDR_WIDTH-1:0]           target_q, target_d;
    logic [ADDR_WIDTH-1:0]           pc_target_q, pc_target_d;
    logic                            pc_load_q, pc_load_d;
    logic [3:0]                      cnt_q, cnt_d;
    logic                            accept;
    logic                            eval_done;

    assign accept    = (state_q == ST_IDLE) && bus.br_valid && (bus.br_control != '0);
    assign eval_done = (state_q == ST_EVAL);

    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        target_d    = target_q;
        pc_target_d = pc_target_q;
        pc_load_d   = 1'b0;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ctrl_d   = bus.br_control;
                    // Modulo 2^ADDR_WIDTH: wrap-around is intentionally silent.
                    target_d = bus.br_pc + bus.br_offset;
                    state_d  = bus.opnd_ready ? ST_EVAL : ST_WAIT_OPND;
                end
            end
            ST_WAIT_OPND: begin
                if (bus.opnd_ready)
                    state_d = ST_EVAL;
            end
            ST_EVAL: begin
                if (bus.cmp_branch) begin
                    state_d     = ST_FLUSH;
                    pc_load_d   = 1'b1;
                    pc_target_d = target_q;
                    cnt_d       = FLUSH_LD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (cnt_q <= 4'd1)
                    state_d = ST_IDLE;
                else
                    cnt_d = cnt_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ctrl_q      <= '0;
            target_q    <= '0;
            pc_target_q <= '0;
            pc_load_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            target_q    <= target_d;
            pc_target_q <= pc_target_d;
            pc_load_q   <= pc_load_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.br_ready    = (state_q == ST_IDLE);
    assign bus.stall       = (state_q == ST_WAIT_OPND) || (state_q == ST_EVAL);
    assign bus.flush       = (state_q == ST_FLUSH);
    assign bus.cmp_control = (state_q == ST_EVAL) ? ctrl_q : '0;
    assign bus.pc_load     = pc_load_q;
    assign bus.pc_target   = pc_target_q;

`ifdef BRANCH_STATS_EN
    branch_stats u_stats (
        .clk               (clk),
        .rst               (rst),
        .eval_done_i       (eval_done),
        .taken_i           (bus.cmp_branch),
        .taken_count_o     (taken_count),
        .not_taken_count_o (not_taken_count)
    );
`else
    logic unused_eval_done;
    assign unused_eval_done = eval_done;
`endif
endmodule
